regfile_write_arbiter: RTL and testbench

- Producer side of the 1-write-port register file: merges every source of architectural register writes into one registered wen/waddr/wdata stream.
- Sources: main pipeline writeback, which is never back-pressured, and a long-latency return channel (mul/div, uncached load) using valid/ready with a small FIFO.
- Keeps a 32-entry pending scoreboard so decode can stall on registers whose long-latency result is outstanding.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/regfile_return_fifo.sv | 58 +++++
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file types for the write-side producers.
// A write request is a destination register plus its 32-bit result.
package cpu_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    function automatic logic [31:0] reg_onehot(input reg_addr_t a);
        return 32'd1 << a;
    endfunction

endpackage

// File: rtl/regfile_return_fifo.sv
// In-order buffer for long-latency register returns.
// DEPTH must be a power of two so the pointers wrap naturally.
module regfile_return_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_req_t          mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline writeback and buffered long-latency returns onto the single
// register-file write port, and tracks outstanding long-latency destinations.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_addr,
    input  logic [31:0]                   wb_data,
    input  logic                          lr_valid,
    output logic                          lr_ready,
    input  logic [4:0]                    lr_addr,
    input  logic [31:0]                   lr_data,
    input  logic                          reserve_valid,
    input  logic [4:0]                    reserve_addr,
    input  logic [4:0]                    chk_a,
    input  logic [4:0]                    chk_b,
    input  logic [4:0]                    chk_w,
    output logic                          hit_a,
    output logic                          hit_b,
    output logic                          hit_w,
    output logic                          pipe_stall,
    output logic                          reserve_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          wen,
    output logic [4:0]                    waddr,
    output logic [31:0]                   wdata
);

    localparam int SW = $clog2(MAX_WAIT + 1);

    wb_req_t          lr_req;
    wb_req_t          head;
    wb_req_t          sel_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             sel_valid;
    logic [SW-1:0]    starve_cnt;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;
    logic [31:0]      clr_mask;
    logic [31:0]      set_mask;
    logic             err_res;
    logic             err_wb;
    logic             err_pop;

    assign lr_req.addr = lr_addr;
    assign lr_req.data = lr_data;

    // lr_ready comes from the registered count, so a full FIFO never sees
    // push and pop on the same edge.
    assign lr_ready = !fifo_full;
    assign push     = lr_valid && lr_ready;
    assign pop      = !wb_valid && !fifo_empty;

    regfile_return_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (lr_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        sel_valid    = wb_valid || pop;
        sel_req.addr = head.addr;
        sel_req.data = head.data;
        if (wb_valid) begin
            sel_req.addr = wb_addr;
            sel_req.data = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (sel_valid) begin
            wen   <= (sel_req.addr != REG_ZERO);
            waddr <= sel_req.addr;
            wdata <= sel_req.data;
        end else begin
            wen   <= 1'b0;
        end
    end

    // A non-empty FIFO that is not popped is necessarily blocked by wb_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(MAX_WAIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign pipe_stall = (starve_cnt == SW'(MAX_WAIT));

    always_comb begin
        clr_mask    = pop ? reg_onehot(head.addr) : 32'd0;
        set_mask    = (reserve_valid && (reserve_addr != REG_ZERO))
                      ? reg_onehot(reserve_addr) : 32'd0;
        pending_nxt = ((pending & ~clr_mask) | set_mask) & ~32'd1;
        err_res     = reserve_valid && pending[reserve_addr] && !clr_mask[reserve_addr];
        err_wb      = wb_valid && pending[wb_addr];
        err_pop     = pop && !pending[head.addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            reserve_err <= 1'b0;
        end else begin
            pending     <= pending_nxt;
            reserve_err <= reserve_err || err_res || err_wb || err_pop;
        end
    end

    assign hit_a = pending[chk_a];
    assign hit_b = pending[chk_b];
    assign hit_w = pending[chk_w];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter: a queue-based reference model
// predicts writes into a scoreboard that an independent monitor drains.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_valid = 1'b0;
    logic [4:0]    wb_addr = '0;
    logic [31:0]   wb_data = '0;
    logic          lr_valid = 1'b0;
    logic          lr_ready;
    logic [4:0]    lr_addr = '0;
    logic [31:0]   lr_data = '0;
    logic          reserve_valid = 1'b0;
    logic [4:0]    reserve_addr = '0;
    logic [4:0]    chk_a = '0;
    logic [4:0]    chk_b = '0;
    logic [4:0]    chk_w = '0;
    logic          hit_a, hit_b, hit_w;
    logic          pipe_stall;
    logic          reserve_err;
    logic [CW-1:0] fifo_count;
    logic          wen;
    logic [4:0]    waddr;
    logic [31:0]   wdata;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .lr_valid      (lr_valid),
        .lr_ready      (lr_ready),
        .lr_addr       (lr_addr),
        .lr_data       (lr_data),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .chk_a         (chk_a),
        .chk_b         (chk_b),
        .chk_w         (chk_w),
        .hit_a         (hit_a),
        .hit_b         (hit_b),
        .hit_w         (hit_w),
        .pipe_stall    (pipe_stall),
        .reserve_err   (reserve_err),
        .fifo_count    (fifo_count),
        .wen           (wen),
        .waddr         (waddr),
        .wdata         (wdata)
    );

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    typedef struct { logic [4:0] a; logic [31:0] d; int due; } exp_t;

    // Reference state: value the DUT should show just after the next edge.
    ent_t        mq[$];
    exp_t        expq[$];
    logic [31:0] m_pend  = '0;
    int          m_starve = 0;
    logic        m_err   = 1'b0;
    logic        m_wen   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_push;
    bit          mon_en = 1'b0;
    logic [4:0]  outst[$];

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit   pop;
        bit   selv;
        ent_t sel;
        m_push = 1'b0;
        if (rst) begin
            mq.delete();
            expq.delete();
            m_pend = '0; m_starve = 0; m_err = 1'b0;
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
            return;
        end
        pop  = !wb_valid && (mq.size() > 0);
        selv = 1'b1;
        sel  = '{5'd0, 32'd0};
        if (wb_valid) begin
            sel = '{wb_addr, wb_data};
            if (m_pend[wb_addr]) m_err = 1'b1;
        end else if (pop) begin
            sel = mq[0];
            if (!m_pend[sel.a]) m_err = 1'b1;
        end else begin
            selv = 1'b0;
        end
        if (reserve_valid && m_pend[reserve_addr] && !(pop && mq[0].a == reserve_addr))
            m_err = 1'b1;
        if (mq.size() == 0 || pop) m_starve = 0;
        else if (m_starve < MAXW) m_starve++;
        if (pop) m_pend[mq[0].a] = 1'b0;
        if (reserve_valid && reserve_addr != 5'd0) m_pend[reserve_addr] = 1'b1;
        m_push = lr_valid && (mq.size() < DEPTH);
        if (pop) mq.delete(0);
        if (m_push) mq.push_back('{lr_addr, lr_data});
        if (selv) begin
            m_waddr = sel.a;
            m_wdata = sel.d;
            m_wen   = (sel.a != 5'd0);
            if (sel.a != 5'd0) expq.push_back('{sel.a, sel.d, cyc + 1});
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic rv, input logic [4:0] ra, input logic r);
        @(negedge clk);
        rst = r;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        lr_valid = lv; lr_addr = la; lr_data = ld;
        reserve_valid = rv; reserve_addr = ra;
        chk_a = 5'($urandom_range(0, 15));
        chk_b = 5'($urandom_range(0, 31));
        chk_w = 5'($urandom_range(0, 15));
        model_update();
        if (r) outst.delete();
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_round(input int n, input int wb_pct, input int lr_pct,
                              input int res_pct, input bit legal);
        for (int i = 0; i < n; i++) begin
            logic        wv, lv, rv, r;
            logic [4:0]  wa, la, ra;
            int          idx;
            wv  = ($urandom_range(0, 99) < wb_pct);
            if (legal && m_starve == MAXW) wv = 1'b0;
            wa  = 5'($urandom_range(0, 31));
            for (int t = 0; t < 8 && legal && m_pend[wa]; t++) wa = 5'($urandom_range(0, 31));
            if (legal && m_pend[wa]) wa = 5'd0;
            lv  = 1'b0; la = '0; idx = -1;
            if (($urandom_range(0, 99) < lr_pct) && outst.size() > 0) begin
                idx = $urandom_range(0, outst.size() - 1);
                lv  = 1'b1; la = outst[idx];
            end else if (!legal && $urandom_range(0, 9) == 0) begin
                lv = 1'b1; la = 5'($urandom_range(0, 31));
            end
            rv  = ($urandom_range(0, 99) < res_pct);
            ra  = 5'($urandom_range(0, 31));
            if (legal && (m_pend[ra] || ra == 5'd0)) rv = 1'b0;
            r   = ($urandom_range(0, 199) == 0);
            step(wv, wa, $urandom, lv, la, $urandom, rv, ra, r);
            if (!r) begin
                if (m_push && idx >= 0) outst.delete(idx);
                if (rv && ra != 5'd0) outst.push_back(ra);
            end
        end
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (wen) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", 32'(waddr), 32'h0);
                end else begin
                    e = expq.pop_front();
                    check("wr_addr", 32'(waddr), 32'(e.a));
                    check("wr_data", wdata, e.d);
                    check("wr_cycle", cyc, e.due);
                end
            end else if (expq.size() > 0 && expq[0].due <= cyc) begin
                e = expq.pop_front();
                check("missing_write", 32'(wen), 32'h1);
            end
            check("wen",         32'(wen),         32'(m_wen));
            check("waddr",       32'(waddr),       32'(m_waddr));
            check("wdata",       wdata,            m_wdata);
            check("lr_ready",    32'(lr_ready),    32'(mq.size() < DEPTH));
            check("fifo_count",  32'(fifo_count),  mq.size());
            check("pipe_stall",  32'(pipe_stall),  32'(m_starve == MAXW));
            check("reserve_err", 32'(reserve_err), 32'(m_err));
            check("hit_a",       32'(hit_a),       32'(m_pend[chk_a]));
            check("hit_b",       32'(hit_b),       32'(m_pend[chk_b]));
            check("hit_w",       32'(hit_w),       32'(m_pend[chk_w]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // pipeline writes, including the silent r0 write
        step(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        step(1, 5'd0, 32'hAAAA_5555, 0, 0, 0, 0, 0, 0);
        idle(2);
        // reserve r7, return it with wb idle
        step(0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
        idle(1);
        step(0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 0);
        idle(3);
        // starvation of r9 behind continuous writebacks
        step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0);
        step(1, 5'd10, 32'h0000_0010, 1, 5'd9, 32'h0000_0909, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 5'(11 + i), $urandom, 0, 0, 0, 0, 0, 0);
        idle(3);
        // backpressure: three returns into a two-deep buffer
        step(0, 0, 0, 0, 0, 0, 1, 5'd1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd2, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
        step(1, 5'd12, 32'hC12, 1, 5'd1, 32'h1111, 0, 0, 0);
        step(1, 5'd13, 32'hC13, 1, 5'd2, 32'h2222, 0, 0, 0);
        step(1, 5'd14, 32'hC14, 1, 5'd3, 32'h3333, 0, 0, 0);
        step(1, 5'd15, 32'hC15, 1, 5'd3, 32'h3333, 0, 0, 0);
        step(0, 0, 0, 1, 5'd3, 32'h3333, 0, 0, 0);
        step(0, 0, 0, 1, 5'd3, 32'h3333, 0, 0, 0);
        idle(3);
        // re-reserve r4 on the edge it pops, then a WAW writeback to it
        step(0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
        step(1, 5'd20, 32'h20, 1, 5'd4, 32'h4444, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd4, 0);
        step(1, 5'd4, 32'hBAD4, 0, 0, 0, 0, 0, 0);
        idle(3);
        // reset with two buffered returns and r3/r6 pending
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 5'd3, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd6, 0);
        step(1, 5'd21, 32'h21, 1, 5'd3, 32'h3030, 0, 0, 0);
        step(1, 5'd22, 32'h22, 1, 5'd6, 32'h6060, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // randomized traffic
        rand_round(400, 50, 40, 30, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rand_round(400, 80, 70, 40, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rand_round(300, 90, 90, 50, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rand_round(300, 20, 60, 60, 1'b1);
        idle(4);
        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
